fetch_unit: RTL and testbench

//  Instruction fetch stage: owns the PC, issues word reads to instruction memory and

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_buffer.sv | 53 +++++
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and helpers for the instruction fetch stage and its buffer.
package fetch_unit_pkg;

    localparam int INSTRUCTION_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_REQUEST = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_FAULT   = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0] instruction;
        logic [31:0]                  pc;
    } fetch_entry_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_buffer.sv
// Small power-of-two FIFO of fetched {instruction, pc} entries; flush beats push and pop.
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [AW:0]  count_o,
    output logic         full_o,
    output logic         empty_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full buffer can still take a push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_entry_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, keeps at most one memory read in flight and buffers results for decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          BUFFER_DEPTH = 2
) (
    // Every channel transfers on a cycle where valid && ready; a raised valid (and its
    // payload) stays put until that transfer happens or a redirect cancels it.
    input  logic         clock,
    input  logic         reset,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic [31:0]  mem_req_addr,
    input  logic         mem_resp_valid,
    input  logic [31:0]  mem_resp_data,
    input  logic         mem_resp_error,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_target,
    output logic         decode_valid,
    input  logic         decode_ready,
    output logic [31:0]  decode_instruction,
    output logic [31:0]  decode_pc,
    output logic         fetch_fault,
    output fetch_state_t debug_state
);

    localparam int AW = $clog2(BUFFER_DEPTH);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  req_addr_q;
    logic         req_valid_q;
    logic         fault_q;

    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic [AW:0]  count;
    logic [AW:0]  count_next;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;
    logic         flush;
    logic         accept;
    logic         redirect;
    logic         resp_in_wait;
    logic         outstanding_after;
    logic         room_next;

    assign accept       = req_valid_q && mem_req_ready;
    assign redirect     = redirect_valid && (state_q != ST_FAULT);
    assign resp_in_wait = (state_q == ST_WAIT) && mem_resp_valid && !redirect;
    assign push         = resp_in_wait && !mem_resp_error && !full;
    assign pop          = decode_valid && decode_ready;
    assign flush        = redirect || (resp_in_wait && mem_resp_error);
    assign push_entry   = '{instruction: mem_resp_data, pc: pc_q};

    // A response landing in the redirect cycle retires the request, so only a still-open
    // request sends the redirect through DISCARD.
    assign outstanding_after = ((state_q == ST_WAIT) || (state_q == ST_DISCARD)) ? !mem_resp_valid
                                                                                  : accept;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign room_next = (count_next < (AW+1)'(BUFFER_DEPTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_REQUEST;
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            fault_q     <= 1'b0;
        end else if (redirect) begin
            req_valid_q <= 1'b0;
            if (redirect_target[1:0] != 2'b00) begin
                state_q <= ST_FAULT;
                fault_q <= 1'b1;
            end else begin
                pc_q <= redirect_target;
                if (outstanding_after) begin
                    state_q <= ST_DISCARD;
                end else begin
                    state_q     <= ST_REQUEST;
                    req_valid_q <= 1'b1;
                    req_addr_q  <= redirect_target;
                end
            end
        end else begin
            case (state_q)
                ST_REQUEST: begin
                    if (accept) begin
                        state_q     <= ST_WAIT;
                        req_valid_q <= 1'b0;
                    end else if (!req_valid_q && room_next) begin
                        req_valid_q <= 1'b1;
                        req_addr_q  <= pc_q;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        if (mem_resp_error) begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            pc_q        <= next_pc(pc_q);
                            state_q     <= ST_REQUEST;
                            req_valid_q <= room_next;
                            req_addr_q  <= next_pc(pc_q);
                        end
                    end
                end
                ST_DISCARD: begin
                    if (mem_resp_valid) begin
                        state_q     <= ST_REQUEST;
                        req_valid_q <= room_next;
                        req_addr_q  <= pc_q;
                    end
                end
                default: begin
                    state_q <= ST_FAULT;
                end
            endcase
        end
    end

    fetch_buffer #(
        .DEPTH(BUFFER_DEPTH)
    ) u_buffer (
        .clk_i       (clock),
        .rst_i       (reset),
        .push_i      (push),
        .push_entry_i(push_entry),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (head),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign mem_req_valid      = req_valid_q;
    assign mem_req_addr       = req_addr_q;
    assign decode_valid       = !empty;
    assign decode_instruction = empty ? '0 : head.instruction;
    assign decode_pc          = empty ? '0 : head.pc;
    assign fetch_fault        = fault_q;
    assign debug_state        = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized phase against a PC-stream model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic         clock = 1'b0;
  logic         reset;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_resp_valid;
  logic [31:0]  mem_resp_data;
  logic         mem_resp_error;
  logic         redirect_valid;
  logic [31:0]  redirect_target;
  logic         decode_valid;
  logic         decode_ready;
  logic [31:0]  decode_instruction;
  logic [31:0]  decode_pc;
  logic         fetch_fault;
  fetch_state_t dbg_state;

  always #5 clock = ~clock;

  fetch_unit #(
    .RESET_PC    (RESET_PC),
    .BUFFER_DEPTH(DEPTH)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_addr      (mem_req_addr),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_data     (mem_resp_data),
    .mem_resp_error    (mem_resp_error),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .decode_valid      (decode_valid),
    .decode_ready      (decode_ready),
    .decode_instruction(decode_instruction),
    .decode_pc         (decode_pc),
    .fetch_fault       (fetch_fault),
    .debug_state       (dbg_state)
  );

  int total_cnt = 0;
  int pass_cnt  = 0;
  int cycle     = 0;
  int pop_cnt   = 0;
  int first_accept;
  int first_valid;

  // Reference model: PCs expected at decode, in order, plus the next fetch PC.
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  logic        model_fault;
  logic        stale;

  // Memory model state.
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_wait;
  int          min_lat;
  int          max_lat;
  logic        err_inject;

  logic        prev_hold;
  logic [31:0] prev_req_addr;
  logic        found;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC0D1} + 32'h0001_0203;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    check("fault_flag", fetch_fault, model_fault);
    check("decode_valid", decode_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("decode_pc", decode_pc, exp_q[0]);
      check("decode_instr", decode_instruction, mem_word(exp_q[0]));
    end
    if (mem_req_valid) begin
      check("req_free_slot", exp_q.size() < DEPTH, 1'b1);
      check("req_bus_idle", mem_busy, 1'b0);
      check("req_addr", mem_req_addr, model_pc);
    end
    if (model_fault) check("fault_no_req", mem_req_valid, 1'b0);
    if (prev_hold) begin
      check("req_hold_valid", mem_req_valid, 1'b1);
      check("req_hold_addr", mem_req_addr, prev_req_addr);
    end
  endtask

  task automatic tick();
    logic acc;
    logic pop;
    logic rsp;
    logic redir;
    logic [31:0] acc_addr;
    acc      = mem_req_valid && mem_req_ready;
    acc_addr = mem_req_addr;
    pop      = decode_valid && decode_ready;
    rsp      = mem_resp_valid;
    redir    = redirect_valid && !model_fault;
    prev_hold     = mem_req_valid && !mem_req_ready && !redirect_valid && !reset;
    prev_req_addr = mem_req_addr;
    if (!reset) begin
      if (acc && first_accept < 0) first_accept = cycle;
      if (pop && !redir) begin
        void'(exp_q.pop_front());
        pop_cnt++;
      end
      if (rsp && !model_fault) begin
        if (stale) begin
          stale = 1'b0;
        end else if (!redir) begin
          if (mem_resp_error) begin
            model_fault = 1'b1;
            exp_q.delete();
          end else begin
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
          end
        end
      end
      if (redir) begin
        exp_q.delete();
        if (redirect_target[1:0] != 2'b00) begin
          model_fault = 1'b1;
        end else begin
          model_pc = redirect_target;
          stale    = acc || (mem_busy && !rsp);
        end
      end
    end
    @(posedge clock);
    #1;
    cycle++;
    if (reset) begin
      exp_q.delete();
      model_pc       = RESET_PC;
      model_fault    = 1'b0;
      stale          = 1'b0;
      prev_hold      = 1'b0;
      mem_busy       = 1'b0;
      mem_wait       = 0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      mem_resp_error = 1'b0;
    end else begin
      if (rsp) begin
        mem_busy       = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        mem_resp_error = 1'b0;
      end
      if (acc) begin
        mem_busy = 1'b1;
        mem_addr = acc_addr;
        mem_wait = $urandom_range(max_lat, min_lat);
      end else if (mem_busy && mem_wait > 0) begin
        mem_wait--;
      end
      if (mem_busy && mem_wait == 0 && !mem_resp_valid) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_word(mem_addr);
        mem_resp_error = err_inject;
        err_inject     = 1'b0;
      end
    end
    check_outputs();
    if (decode_valid && first_valid < 0) first_valid = cycle;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    mem_resp_error = 1'b0; redirect_valid = 1'b0; redirect_target = '0; decode_ready = 1'b0;
    min_lat = 0; max_lat = 0; err_inject = 1'b0; mem_busy = 1'b0; mem_wait = 0; mem_addr = '0;
    stale = 1'b0; model_fault = 1'b0; model_pc = RESET_PC; prev_hold = 1'b0; prev_req_addr = '0;
    first_accept = -1; first_valid = -1;

    // Reset values.
    do_reset();
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_req_addr", mem_req_addr, 32'h0);
    check("rst_decode_valid", decode_valid, 1'b0);
    check("rst_decode_pc", decode_pc, 32'h0);
    check("rst_decode_instr", decode_instruction, 32'h0);
    check("rst_fault", fetch_fault, 1'b0);

    // 1: zero-latency memory, decode always ready.
    mem_req_ready = 1'b1; decode_ready = 1'b1;
    first_accept = -1; first_valid = -1; pop_cnt = 0;
    repeat (20) tick();
    check("t1_first_valid_latency", 32'(first_valid - first_accept), 32'd2);
    check("t1_progress", pop_cnt >= 8, 1'b1);

    // 2: decode stalled -> two entries held, no request, then resume at pc 8.
    do_reset();
    decode_ready = 1'b0;
    repeat (12) tick();
    check("t2_held_valid", decode_valid, 1'b1);
    check("t2_held_head", decode_pc, 32'h0);
    check("t2_no_req", mem_req_valid, 1'b0);
    decode_ready = 1'b1;
    tick();
    check("t2_second_head", decode_pc, 32'h4);
    check("t2_resume_valid", mem_req_valid, 1'b1);
    check("t2_resume_addr", mem_req_addr, 32'h8);
    repeat (16) tick();

    // 3: redirect while a request is in flight.
    min_lat = 2; max_lat = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = mem_busy && !mem_resp_valid && !stale;
    end
    check("t3_wait_seen", found, 1'b1);
    redirect_valid = 1'b1; redirect_target = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("t3_flushed", decode_valid, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = mem_req_valid;
    end
    check("t3_req_seen", found, 1'b1);
    check("t3_req_addr", mem_req_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = decode_valid;
    end
    check("t3_decode_seen", found, 1'b1);
    check("t3_decode_pc", decode_pc, 32'h100);
    repeat (6) tick();

    // 4: redirect coinciding with a response and a pop.
    min_lat = 0; max_lat = 0;
    do_reset();
    decode_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = mem_resp_valid && decode_valid;
    end
    check("t4_setup_seen", found, 1'b1);
    decode_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
    tick();
    redirect_valid = 1'b0;
    check("t4_flushed", decode_valid, 1'b0);
    check("t4_req_valid", mem_req_valid, 1'b1);
    check("t4_req_addr", mem_req_addr, 32'h200);
    repeat (8) tick();

    // 5: misaligned redirect target faults; later redirects are ignored.
    redirect_valid = 1'b1; redirect_target = 32'h102;
    tick();
    redirect_valid = 1'b0;
    check("t5_fault", fetch_fault, 1'b1);
    repeat (6) tick();
    redirect_valid = 1'b1; redirect_target = 32'h300;
    tick();
    redirect_valid = 1'b0;
    repeat (6) tick();
    check("t5_fault_sticky", fetch_fault, 1'b1);
    check("t5_no_req", mem_req_valid, 1'b0);
    check("t5_no_decode", decode_valid, 1'b0);
    check("t5_state", dbg_state, ST_FAULT);

    // 6: bus error faults; reset recovers at RESET_PC.
    do_reset();
    repeat (6) tick();
    err_inject = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = fetch_fault;
    end
    check("t6_fault_seen", found, 1'b1);
    repeat (5) tick();
    check("t6_fault_sticky", fetch_fault, 1'b1);
    do_reset();
    check("t6_fault_cleared", fetch_fault, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = mem_req_valid;
    end
    check("t6_req_seen", found, 1'b1);
    check("t6_req_addr", mem_req_addr, RESET_PC);
    repeat (6) tick();

    // PC wrap-around past the top of the address space.
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    pop_cnt = 0;
    repeat (16) tick();
    check("wrap_progress", pop_cnt >= 4, 1'b1);

    // Randomized traffic: stalls on both sides, variable latency, aligned redirects.
    min_lat = 0; max_lat = 3;
    for (int i = 0; i < 800; i++) begin
      mem_req_ready   = ($urandom_range(3, 0) != 0);
      decode_ready    = ($urandom_range(2, 0) != 0);
      redirect_valid  = ($urandom_range(30, 0) == 0);
      redirect_target = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    redirect_valid = 1'b0;
    repeat (10) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
